// File: rtl/pwm_mau_lanes_if.sv
// rtl/pwm_mau_lanes_if.sv - stream handshake bundle for the pwm_mau_lanes multiplier
interface pwm_mau_lanes_if #(
  parameter int WIDTH = 24,
  parameter int LANES = 4,
  parameter int TAG_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic [LANES*WIDTH-1:0] in_c;
  logic                   in_mac;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_o;
  logic [TAG_W-1:0]       out_tag;
  logic                   busy;

  modport master (
    output in_valid, in_a, in_b, in_c, in_mac, in_tag, out_ready,
    input  in_ready, out_valid, out_o, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_mac, in_tag, out_ready,
    output in_ready, out_valid, out_o, out_tag, busy
  );
endinterface

// File: rtl/pwm_mau_lanes.sv
// rtl/pwm_mau_lanes.sv - multi-lane 3-stage Barrett pointwise multiplier, (a*b [+c]) mod Q
// Defining PWM_MAU_MAC_EN builds the per-beat multiply-accumulate adder in S3.
module pwm_mau_lanes #(
  parameter int WIDTH     = 24,
  parameter int LANES     = 4,
  parameter int Q         = 8380417,
  parameter int BARRETT_K = 23,
  parameter int BARRETT_M = 8396807,
  parameter int TAG_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  pwm_mau_lanes_if.slave bus
);
  localparam int P_W  = 2 * WIDTH;
  localparam int PS_W = P_W - (BARRETT_K - 1);
  localparam int M_W  = BARRETT_K + 1;
  localparam int PM_W = PS_W + M_W;
  localparam int QE_W = PM_W - (BARRETT_K + 1);
  localparam int A_W  = QE_W + BARRETT_K;

  localparam logic [M_W-1:0] M_C = M_W'(BARRETT_M);
  localparam logic [A_W-1:0] Q_A = A_W'(Q);

  logic             adv;
  logic             s1_valid, s2_valid, s3_valid;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
  logic [LANES-1:0][WIDTH-1:0] out_q;

  // The whole pipe moves as one unit whenever S3 is empty or being drained.
  assign adv           = bus.out_ready | ~s3_valid;
  assign bus.in_ready  = adv;
  assign bus.out_valid = s3_valid;
  assign bus.out_tag   = s3_tag;
  assign bus.out_o     = out_q;
  assign bus.busy      = s1_valid | s2_valid | s3_valid;

`ifdef PWM_MAU_MAC_EN
  logic s1_mac, s2_mac;
`else
  logic unused_mac;
  assign unused_mac = ^{bus.in_c, bus.in_mac};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_tag   <= '0;
      s2_tag   <= '0;
      s3_tag   <= '0;
`ifdef PWM_MAU_MAC_EN
      s1_mac   <= 1'b0;
      s2_mac   <= 1'b0;
`endif
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s1_tag   <= bus.in_tag;
      s2_tag   <= s1_tag;
      s3_tag   <= s2_tag;
`ifdef PWM_MAU_MAC_EN
      s1_mac   <= bus.in_mac;
      s2_mac   <= s1_mac;
`endif
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] a, b;
    logic [P_W-1:0]   s1_p, s2_p;
    logic [QE_W-1:0]  s2_qe;
    logic [PM_W-1:0]  qe_prod;
    logic [A_W-1:0]   qq, r0, r1, r2, res;
    logic [WIDTH-1:0] s3_o;
    logic             unused_bits;

    assign a = bus.in_a[i*WIDTH +: WIDTH];
    assign b = bus.in_b[i*WIDTH +: WIDTH];

    assign qe_prod = {{M_W{1'b0}}, s1_p[P_W-1:BARRETT_K-1]} * {{PS_W{1'b0}}, M_C};

    // Barrett remainder lands in [0, 3Q); two compare-selected subtractions finish it.
    assign qq = {{BARRETT_K{1'b0}}, s2_qe} * Q_A;
    assign r0 = {1'b0, s2_p} - qq;
    assign r1 = (r0 >= Q_A) ? (r0 - Q_A) : r0;
    assign r2 = (r1 >= Q_A) ? (r1 - Q_A) : r1;

`ifdef PWM_MAU_MAC_EN
    logic [WIDTH-1:0] s1_c, s2_c;
    logic [A_W-1:0]   sum, sum_c;

    assign sum   = r2 + {{(A_W-WIDTH){1'b0}}, s2_c};
    assign sum_c = (sum >= Q_A) ? (sum - Q_A) : sum;
    assign res   = s2_mac ? sum_c : r2;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_c <= '0;
        s2_c <= '0;
      end else if (adv) begin
        s1_c <= bus.in_c[i*WIDTH +: WIDTH];
        s2_c <= s1_c;
      end
    end
`else
    assign res = r2;
`endif

    assign unused_bits = ^{qe_prod[BARRETT_K:0], res[A_W-1:WIDTH]};

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_p  <= '0;
        s2_p  <= '0;
        s2_qe <= '0;
        s3_o  <= '0;
      end else if (adv) begin
        s1_p  <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        s2_p  <= s1_p;
        s2_qe <= qe_prod[PM_W-1:BARRETT_K+1];
        s3_o  <= res[WIDTH-1:0];
      end
    end

    assign out_q[i] = s3_o;
  end
endmodule

// File: tb/tb_pwm_mau_lanes.sv
// tb/tb_pwm_mau_lanes.sv - directed table, random streams and reset checks for pwm_mau_lanes
module tb_pwm_mau_lanes;
  localparam int W = 24;
  localparam int L = 4;
  localparam int T = 8;
  localparam int unsigned QI = 8380417;
  localparam longint unsigned QV = 64'd8380417;
`ifdef PWM_MAU_MAC_EN
  localparam bit MAC_ON = 1'b1;
`else
  localparam bit MAC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_mau_lanes_if #(.WIDTH(W), .LANES(L), .TAG_W(T)) bus ();

  pwm_mau_lanes #(
    .WIDTH(W), .LANES(L), .Q(8380417), .BARRETT_K(23), .BARRETT_M(8396807), .TAG_W(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [L*W-1:0] o;
    logic [T-1:0]   tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [W-1:0] a, b, c;
    logic         mac;
    logic [T-1:0] tag;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [L*W-1:0] model(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                           input logic [L*W-1:0] c, input logic mac);
    logic [L*W-1:0] r;
    longint unsigned av, bv, cv, x;
    r = '0;
    for (int i = 0; i < L; i++) begin
      av = 64'(a[i*W +: W]);
      bv = 64'(b[i*W +: W]);
      cv = 64'(c[i*W +: W]);
      x  = av * bv;
      if (mac && MAC_ON) x = x + cv;
      x = x % QV;
      r[i*W +: W] = x[W-1:0];
    end
    return r;
  endfunction

  task automatic rand_beat(input logic [T-1:0] tag);
    for (int i = 0; i < L; i++) begin
      bus.in_a[i*W +: W] = W'($urandom_range(0, QI - 1));
      bus.in_b[i*W +: W] = W'($urandom_range(0, QI - 1));
      bus.in_c[i*W +: W] = W'($urandom_range(0, QI - 1));
    end
    bus.in_mac = 1'($urandom_range(0, 1));
    bus.in_tag = tag;
  endtask

  // mode 0: full rate; 1: random valid/ready; 2: 4-cycle stall mid-stream
  task automatic run_stream(input int n, input int mode, input int max_cyc, output int cyc);
    int   sent;
    logic pend, fin, fout;
    exp_t e;
    sent = 0;
    cyc  = 0;
    pend = 1'b0;
    bus.in_valid = 1'b0;
    while ((sent < n || sb.size() != 0) && cyc < max_cyc) begin
      if (!pend) begin
        if (sent < n && (mode != 1 || $urandom_range(0, 3) != 0)) begin
          rand_beat(T'(sent));
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      case (mode)
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = !(cyc >= 4 && cyc < 8);
        default: bus.out_ready = 1'b1;
      endcase
      @(negedge clk);
      fin  = bus.in_valid & bus.in_ready;
      fout = bus.out_valid & bus.out_ready;
      if (mode == 2 && cyc >= 4 && cyc < 8) check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      if (fout) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got tag %0h expected no beat", bus.out_tag);
        end else begin
          e = sb.pop_front();
          check("out_tag", 128'(bus.out_tag), 128'(e.tag));
          check("out_o", 128'(bus.out_o), 128'(e.o));
        end
      end
      if (fin) begin
        e.o   = model(bus.in_a, bus.in_b, bus.in_c, bus.in_mac);
        e.tag = bus.in_tag;
        sb.push_back(e);
        sent++;
      end
      pend = bus.in_valid & ~fin;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_sent", 128'(sent), 128'(n));
    check("stream_drained", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    bus.in_mac = 1'b0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;

    vecs[0] = '{a: 24'd1,       b: 24'd1,       c: 24'd0,       mac: 1'b0, tag: 8'h5A, exp: 24'd1};
    vecs[1] = '{a: 24'd8380416, b: 24'd8380416, c: 24'd0,       mac: 1'b0, tag: 8'h11, exp: 24'd1};
    vecs[2] = '{a: 24'd4194304, b: 24'd2,       c: 24'd0,       mac: 1'b0, tag: 8'h22, exp: 24'd8191};
    vecs[3] = '{a: 24'd0,       b: 24'd8380416, c: 24'd0,       mac: 1'b0, tag: 8'h33, exp: 24'd0};
`ifdef PWM_MAU_MAC_EN
    vecs[4] = '{a: 24'd8380416, b: 24'd1,       c: 24'd1,       mac: 1'b1, tag: 8'h44, exp: 24'd0};
    vecs[5] = '{a: 24'd2,       b: 24'd3,       c: 24'd8380416, mac: 1'b1, tag: 8'h55, exp: 24'd5};
`else
    vecs[4] = '{a: 24'd8380416, b: 24'd1,       c: 24'd1,       mac: 1'b1, tag: 8'h44, exp: 24'd8380416};
    vecs[5] = '{a: 24'd2,       b: 24'd3,       c: 24'd8380416, mac: 1'b1, tag: 8'h55, exp: 24'd6};
`endif

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_o", 128'(bus.out_o), 128'd0);
    check("rst_out_tag", 128'(bus.out_tag), 128'd0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) begin
      bus.in_a = {L{vecs[k].a}};
      bus.in_b = {L{vecs[k].b}};
      bus.in_c = {L{vecs[k].c}};
      bus.in_mac = vecs[k].mac;
      bus.in_tag = vecs[k].tag;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("dir%0d_in_ready", k), 128'(bus.in_ready), 128'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("dir%0d_lat1", k), 128'(bus.out_valid), 128'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("dir%0d_lat2", k), 128'(bus.out_valid), 128'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("dir%0d_lat3_valid", k), 128'(bus.out_valid), 128'd1);
      check($sformatf("dir%0d_out", k), 128'(bus.out_o), 128'({L{vecs[k].exp}}));
      check($sformatf("dir%0d_tag", k), 128'(bus.out_tag), 128'(vecs[k].tag));
      @(posedge clk);
      #1;
    end

    run_stream(10000, 0, 12000, cyc);
    check("full_rate_cycles", 128'(cyc), 128'd10003);
    run_stream(8, 2, 200, cyc);
    run_stream(1000, 1, 20000, cyc);

    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_beat(8'hE0 + 8'(k));
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 128'(bus.busy), 128'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("mid_rst_busy", 128'(bus.busy), 128'd0);
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("post_rst_no_emit", 128'(seen), 128'd0);
    @(posedge clk);
    #1;
    run_stream(50, 1, 2000, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
